// File: rtl/pipeline_stream_collector_pkg.sv
// pipeline_collect_pkg: shared defaults, stat width and width helpers for pipeline_stream_collector
package pipeline_collect_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STAT_W = 32;
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pipeline_stream_collector_if.sv
// pipeline_stream_collector_if: issue, pipeline-result and downstream stream signals of the collector
interface pipeline_stream_collector_if
  import pipeline_collect_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  issue_valid;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  overflow_err;
  modport master (
    output in_valid, pipe_valid, pipe_data, out_ready,
    input  in_ready, issue_valid, out_valid, out_data, overflow_err
  );
  modport slave (
    input  in_valid, pipe_valid, pipe_data, out_ready,
    output in_ready, issue_valid, out_valid, out_data, overflow_err
  );
endinterface

// File: rtl/pipeline_stream_collector_fifo.sv
// pipeline_collect_fifo: DEPTH x DATA_WIDTH register FIFO, fall-through head, sticky overflow on push into full
module pipeline_collect_fifo
  import pipeline_collect_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [credit_width(DEPTH)-1:0] count,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow
);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = credit_width(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  // storage write; a push on a full FIFO with a pop reuses the slot just freed
  always_ff @(posedge clk)
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  // pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= do_push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr   <= do_pop ? nxt(rd_ptr) : rd_ptr;
      count    <= count + CW'(do_push) - CW'(do_pop);
      overflow <= overflow || (push && !do_push);
    end
endmodule

// File: rtl/pipeline_stream_collector.sv
// pipeline_stream_collector: credit-throttled ready/valid collector for valid-only pipelines; stats under PIPE_COLLECT_STATS_EN
module pipeline_stream_collector
  import pipeline_collect_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  pipeline_stream_collector_if.slave bus
`ifdef PIPE_COLLECT_STATS_EN
  ,
  output logic [STAT_W-1:0]          stat_issued,
  output logic [STAT_W-1:0]          stat_stall,
  output logic [STAT_W-1:0]          stat_backpressure
`endif
);
  localparam int CREDIT_W = credit_width(DEPTH);
  logic [CREDIT_W-1:0] credits, count;
  logic issue, pop, full, empty;
  assign bus.in_ready    = credits != '0 && !rst;
  assign issue           = bus.in_valid && bus.in_ready;
  assign bus.issue_valid = issue;
  assign bus.out_valid   = !empty;
  assign pop             = bus.out_valid && bus.out_ready;
  // one credit per free FIFO slot not already claimed by an in-flight beat
  always_ff @(posedge clk)
    credits <= rst ? CREDIT_W'(DEPTH) : credits - CREDIT_W'(issue) + CREDIT_W'(pop);
  pipeline_collect_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.pipe_valid),
    .push_data(bus.pipe_data),
    .pop      (pop),
    .rd_data  (bus.out_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (bus.overflow_err)
  );
  // credits and buffered beats can never exceed DEPTH, and a full FIFO holds every credit
  assert property (@(posedge clk) disable iff (rst)
    (int'(credits) + int'(count) <= DEPTH) && (!full || credits == '0));
`ifdef PIPE_COLLECT_STATS_EN
  // free-running issue, upstream-stall and downstream-backpressure counters
  always_ff @(posedge clk)
    if (rst) begin
      stat_issued       <= '0;
      stat_stall        <= '0;
      stat_backpressure <= '0;
    end else begin
      stat_issued       <= stat_issued + STAT_W'(issue);
      stat_stall        <= stat_stall + STAT_W'(bus.in_valid && !bus.in_ready);
      stat_backpressure <= stat_backpressure + STAT_W'(bus.out_valid && !bus.out_ready);
    end
`endif
endmodule
